// File: rtl/nibble_serial_adder_ctrl_pkg.sv
// Shared types and constants for the nibble-serial adder controller.
package serial_adder_pkg;

   localparam int NIBBLE_W = 4;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      RUN  = 2'b01,
      DONE = 2'b10
   } state_t;

endpackage

// File: rtl/nibble_serial_adder_ctrl_if.sv
// Operand/result handshake bundle for the nibble-serial adder.
// Optional `sub` signal exists only when SERIAL_ADD_SUB_EN is defined.
interface nibble_serial_adder_ctrl_if #(parameter int WIDTH = 16);

   logic             op_valid;
   logic             op_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             cin;
`ifdef SERIAL_ADD_SUB_EN
   logic             sub;
`endif
   logic             res_valid;
   logic             res_ready;
   logic [WIDTH-1:0] sum;
   logic             cout;
   logic             busy;

   modport master (
`ifdef SERIAL_ADD_SUB_EN
      output sub,
`endif
      output op_valid, a, b, cin, res_ready,
      input  op_ready, res_valid, sum, cout, busy
   );

   modport slave (
`ifdef SERIAL_ADD_SUB_EN
      input  sub,
`endif
      input  op_valid, a, b, cin, res_ready,
      output op_ready, res_valid, sum, cout, busy
   );

endinterface

// File: rtl/nibble_serial_adder_ctrl_adder4.sv
// 4-bit ripple-carry adder slice; the shared datapath the controller sequences.
module nibble_adder4
   import serial_adder_pkg::*;
(
   input  logic [NIBBLE_W-1:0] a,
   input  logic [NIBBLE_W-1:0] b,
   input  logic                ci,
   output logic [NIBBLE_W-1:0] s,
   output logic                co
);

   logic [NIBBLE_W:0] c;

   assign c[0] = ci;

   for (genvar i = 0; i < NIBBLE_W; i++) begin : g_fa
      assign s[i]   = a[i] ^ b[i] ^ c[i];
      assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
   end

   assign co = c[NIBBLE_W];

endmodule

// File: rtl/nibble_serial_adder_ctrl.sv
// Adds WIDTH-bit operands one nibble per cycle through a single 4-bit slice, LSB first.
// Define SERIAL_ADD_SUB_EN to add a `sub` input that turns the operation into a-b.
module nibble_serial_adder_ctrl
   import serial_adder_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic                      clk,
   input  logic                      rst_n,
   nibble_serial_adder_ctrl_if.slave bus
);

   localparam int NIBBLES = WIDTH / NIBBLE_W;
   localparam int IDX_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

   localparam logic [1:0] S_IDLE = IDLE;
   localparam logic [1:0] S_RUN  = RUN;
   localparam logic [1:0] S_DONE = DONE;

   if ((WIDTH % NIBBLE_W) != 0 || WIDTH < 8) begin : g_bad_width
      $error("nibble_serial_adder_ctrl: WIDTH must be a multiple of 4 and >= 8");
   end

   logic [1:0]       state;
   logic [IDX_W-1:0] idx;
   logic [IDX_W+1:0] base;
   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] b_q;
   logic [WIDTH-1:0] sum_q;
   logic             carry;
   logic             cout_q;
   logic             last;

   logic [NIBBLE_W-1:0] nib_a;
   logic [NIBBLE_W-1:0] nib_b;
   logic [NIBBLE_W-1:0] nib_s;
   logic                nib_c;

   // Bit offset of the current nibble: idx * 4.
   assign base  = {idx, 2'b00};
   assign nib_a = a_q[base +: NIBBLE_W];
   assign nib_b = b_q[base +: NIBBLE_W];
   assign last  = (idx == IDX_W'(NIBBLES - 1));

   nibble_adder4 u_add (
      .a  (nib_a),
      .b  (nib_b),
      .ci (carry),
      .s  (nib_s),
      .co (nib_c)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state  <= S_IDLE;
         idx    <= '0;
         carry  <= 1'b0;
         sum_q  <= '0;
         cout_q <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (bus.op_valid) begin
                  a_q   <= bus.a;
`ifdef SERIAL_ADD_SUB_EN
                  // Subtract as a + ~b + 1; cin has no meaning in that mode.
                  b_q   <= bus.sub ? ~bus.b : bus.b;
                  carry <= bus.sub | bus.cin;
`else
                  b_q   <= bus.b;
                  carry <= bus.cin;
`endif
                  idx   <= '0;
                  sum_q <= '0;
                  state <= S_RUN;
               end
            end
            S_RUN: begin
               sum_q[base +: NIBBLE_W] <= nib_s;
               carry <= nib_c;
               idx   <= idx + 1'b1;
               if (last) begin
                  cout_q <= nib_c;
                  state  <= S_DONE;
               end
            end
            S_DONE: begin
               if (bus.res_ready) state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   assign bus.op_ready  = (state == S_IDLE);
   assign bus.res_valid = (state == S_DONE);
   assign bus.busy      = (state == S_RUN) || (state == S_DONE);
   assign bus.sum       = sum_q;
   assign bus.cout      = cout_q;

endmodule
